// File: rtl/multiplier_arbiter.sv
// multiplier_arbiter
// Shares one external multiplier between four requesters using round-robin
// arbitration. A grant latches the winner's operands onto MulA/MulB and raises
// MulStart until the multiplier drops MulReady; the result is captured when
// MulReady rises again. If MulReady never falls, the operation is aborted
// after START_TIMEOUT sampled-ready cycles and Err is pulsed instead.
//
// Ports
//   Clk, Rst_n      clock (rising edge), asynchronous active-low reset
//   ReqValid[3:0]   per-requester request, held until ReqAck
//   ReqA, ReqB      packed operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ReqAck[3:0]     one-cycle pulse: operands captured
//   RespValid[3:0]  one-cycle pulse: Product valid for that requester
//   Err[3:0]        one-cycle pulse: operation aborted on start timeout
//   Product         last result, held until the next response
//   Grant           index of the current or last owner
//   Busy            high while an operation is in flight
//   MulA, MulB      operands to the multiplier
//   MulStart        multiplier start request
//   MulProduct      multiplier result
//   MulReady        multiplier idle / result valid
module multiplier_arbiter #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned START_TIMEOUT = 16
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic [3:0]              ReqValid,
    input  logic [4*DATA_WIDTH-1:0] ReqA,
    input  logic [4*DATA_WIDTH-1:0] ReqB,
    output logic [3:0]              ReqAck,
    output logic [3:0]              RespValid,
    output logic [3:0]              Err,
    output logic [2*DATA_WIDTH-1:0] Product,
    output logic [1:0]              Grant,
    output logic                    Busy,
    output logic [DATA_WIDTH-1:0]   MulA,
    output logic [DATA_WIDTH-1:0]   MulB,
    output logic                    MulStart,
    input  logic [2*DATA_WIDTH-1:0] MulProduct,
    input  logic                    MulReady
);

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned PROD_W  = 2 * DATA_WIDTH;
    localparam int unsigned CNT_W   = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [1:0]              last_q, last_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [3:0]              ack_q, ack_d;
    logic [3:0]              resp_q, resp_d;
    logic [3:0]              err_q, err_d;
    logic [PROD_W-1:0]       product_q, product_d;
    logic [1:0]              grant_q, grant_d;
    logic                    busy_q, busy_d;
    logic [DATA_WIDTH-1:0]   mul_a_q, mul_a_d;
    logic [DATA_WIDTH-1:0]   mul_b_q, mul_b_d;
    logic                    mul_start_q, mul_start_d;

    logic [DATA_WIDTH-1:0]   req_a [NUM_REQ];
    logic [DATA_WIDTH-1:0]   req_b [NUM_REQ];
    logic                    win_found;
    logic [1:0]              win_idx;

    // Round-robin pick: search last+1, last+2, last+3, last (mod 4).
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] cand;
        logic       found;
        logic [1:0] idx;
        found = 1'b0;
        idx   = last;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = last + 2'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    // Unpack the operand buses per requester.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_a[i] = ReqA[i*DATA_WIDTH +: DATA_WIDTH];
            req_b[i] = ReqB[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign {win_found, win_idx} = rr_pick(ReqValid, last_q);

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        ack_d       = '0;
        resp_d      = '0;
        err_d       = '0;
        product_d   = product_q;
        grant_d     = grant_q;
        busy_d      = busy_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        mul_start_d = mul_start_q;

        unique case (state_q)
            IDLE: begin
                // A grant needs both a request and an idle multiplier.
                if (win_found && MulReady) begin
                    state_d     = START;
                    last_d      = win_idx;
                    grant_d     = win_idx;
                    ack_d       = 4'b0001 << win_idx;
                    mul_a_d     = req_a[win_idx];
                    mul_b_d     = req_b[win_idx];
                    mul_start_d = 1'b1;
                    busy_d      = 1'b1;
                    cnt_d       = '0;
                end
            end
            START: begin
                if (!MulReady) begin
                    mul_start_d = 1'b0;
                    state_d     = RUN;
                end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
                    // This sample brings the ready count to START_TIMEOUT: abort.
                    mul_start_d = 1'b0;
                    err_d       = 4'b0001 << grant_q;
                    busy_d      = 1'b0;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (MulReady) begin
                    product_d = MulProduct;
                    resp_d    = 4'b0001 << grant_q;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                mul_start_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            last_q      <= 2'd3;
            cnt_q       <= '0;
            ack_q       <= '0;
            resp_q      <= '0;
            err_q       <= '0;
            product_q   <= '0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            ack_q       <= ack_d;
            resp_q      <= resp_d;
            err_q       <= err_d;
            product_q   <= product_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_start_q <= mul_start_d;
        end
    end

    assign ReqAck    = ack_q;
    assign RespValid = resp_q;
    assign Err       = err_q;
    assign Product   = product_q;
    assign Grant     = grant_q;
    assign Busy      = busy_q;
    assign MulA      = mul_a_q;
    assign MulB      = mul_b_q;
    assign MulStart  = mul_start_q;

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Bench for multiplier_arbiter: a transaction-level model predicts every
// output each cycle, a behavioural multiplier answers MulStart, and directed
// scenarios pin the model with hand-computed results.
module tb_multiplier_arbiter;

    localparam int unsigned DW = 16;
    localparam int TO = 16;

    logic            Clk = 1'b0;
    logic            Rst_n;
    logic [3:0]      ReqValid;
    logic [4*DW-1:0] ReqA, ReqB;
    logic [3:0]      ReqAck, RespValid, Err;
    logic [2*DW-1:0] Product;
    logic [1:0]      Grant;
    logic            Busy;
    logic [DW-1:0]   MulA, MulB;
    logic            MulStart;
    logic [2*DW-1:0] MulProduct;
    logic            MulReady;

    multiplier_arbiter #(.DATA_WIDTH(DW), .START_TIMEOUT(TO)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .ReqValid(ReqValid), .ReqA(ReqA), .ReqB(ReqB),
        .ReqAck(ReqAck), .RespValid(RespValid), .Err(Err), .Product(Product),
        .Grant(Grant), .Busy(Busy), .MulA(MulA), .MulB(MulB), .MulStart(MulStart),
        .MulProduct(MulProduct), .MulReady(MulReady)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Inputs as the DUT saw them at the last rising edge.
    logic            s_rstn = 1'b0;
    logic [3:0]      s_req;
    logic [4*DW-1:0] s_a, s_b;
    logic            s_mready;
    logic [2*DW-1:0] s_mprod;

    always @(posedge Clk) begin
        s_rstn   <= Rst_n;
        s_req    <= ReqValid;
        s_a      <= ReqA;
        s_b      <= ReqB;
        s_mready <= MulReady;
        s_mprod  <= MulProduct;
    end

    // Transaction-level model: one operation in flight, owner, last winner.
    bit              m_active, m_in_start;
    int              m_owner, m_last, m_tcnt;
    logic [3:0]      e_ack, e_resp, e_err;
    logic [2*DW-1:0] e_prod;
    logic [1:0]      e_grant;
    logic            e_busy, e_mstart;
    logic [DW-1:0]   e_mula, e_mulb;

    task automatic model_reset();
        m_active = 0; m_in_start = 0; m_owner = 0; m_last = 3; m_tcnt = 0;
        e_ack = '0; e_resp = '0; e_err = '0; e_prod = '0; e_grant = '0;
        e_busy = 0; e_mstart = 0; e_mula = '0; e_mulb = '0;
    endtask

    task automatic model_step();
        int w;
        e_ack = '0; e_resp = '0; e_err = '0;
        if (!m_active) begin
            w = -1;
            if (s_req != 0 && s_mready) begin
                for (int d = 1; d <= 4; d++)
                    if (w < 0 && s_req[(m_last + d) % 4]) w = (m_last + d) % 4;
            end
            if (w >= 0) begin
                m_active = 1; m_in_start = 1; m_owner = w; m_last = w; m_tcnt = 0;
                e_ack = 4'(1 << w); e_grant = 2'(w);
                e_mula = s_a[w*DW +: DW]; e_mulb = s_b[w*DW +: DW];
                e_mstart = 1; e_busy = 1;
            end
        end else if (m_in_start) begin
            if (!s_mready) begin
                m_in_start = 0; e_mstart = 0;
            end else begin
                m_tcnt++;
                if (m_tcnt == TO) begin
                    m_active = 0; m_in_start = 0;
                    e_mstart = 0; e_busy = 0; e_err = 4'(1 << m_owner);
                end
            end
        end else if (s_mready) begin
            m_active = 0; e_busy = 0;
            e_prod = s_mprod; e_resp = 4'(1 << m_owner);
        end
    endtask

    // Behavioural multiplier.
    bit              mm_ignore = 0;
    bit              mm_busy = 0;
    int              mm_start_delay = 0, mm_lat = 3, mm_seen = 0, mm_wait = 0;
    logic [2*DW-1:0] mm_res;

    int ack_log[$];
    logic [2*DW-1:0] prod_log[$];

    // Per-cycle model update, comparison, logging and multiplier response.
    always @(negedge Clk) begin
        if (!Rst_n || !s_rstn) model_reset();
        else model_step();
        if (chk_en) begin
            chk("ReqAck", 64'(ReqAck), 64'(e_ack));
            chk("RespValid", 64'(RespValid), 64'(e_resp));
            chk("Err", 64'(Err), 64'(e_err));
            chk("Product", 64'(Product), 64'(e_prod));
            chk("Grant", 64'(Grant), 64'(e_grant));
            chk("Busy", 64'(Busy), 64'(e_busy));
            chk("MulA", 64'(MulA), 64'(e_mula));
            chk("MulB", 64'(MulB), 64'(e_mulb));
            chk("MulStart", 64'(MulStart), 64'(e_mstart));
        end
        for (int j = 0; j < 4; j++) if (ReqAck[j]) ack_log.push_back(j);
        if (RespValid != 0) prod_log.push_back(Product);
        if (mm_ignore) begin
            MulReady = 1'b1; mm_busy = 0; mm_seen = 0;
        end else if (mm_busy) begin
            if (mm_wait > 0) mm_wait--;
            else begin MulReady = 1'b1; MulProduct = mm_res; mm_busy = 0; end
        end else if (MulStart && MulReady) begin
            if (mm_seen >= mm_start_delay) begin
                MulReady = 1'b0; MulProduct = 32'hDEADBEEF;
                mm_res = 32'(MulA) * 32'(MulB);
                mm_wait = mm_lat; mm_busy = 1; mm_seen = 0;
            end else mm_seen++;
        end else mm_seen = 0;
    end

    task automatic run_single(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b,
                              output logic [2*DW-1:0] prod, output logic [3:0] resp);
        bit done;
        done = 0; prod = '0; resp = '0;
        @(negedge Clk);
        ReqA[idx*DW +: DW] = a; ReqB[idx*DW +: DW] = b; ReqValid[idx] = 1'b1;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge Clk);
            if (ReqAck[idx]) ReqValid[idx] = 1'b0;
            if (RespValid != 0) begin prod = Product; resp = RespValid; done = 1; end
        end
        chk("single_done", 64'(done), 64'(1));
    endtask

    task automatic do_reset();
        @(posedge Clk); #2 Rst_n = 1'b0;
        @(negedge Clk); @(negedge Clk); #1 Rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2*DW-1:0] p;
        logic [3:0] r;
        int n_ack, n_resp, low_run, max_low, c_ack, c_err, resp_seen;
        logic [3:0] err_v;
        logic [2*DW-1:0] err_prod;
        logic err_mstart, err_busy;
        bit done;

        Rst_n = 1'b0; ReqValid = '0; ReqA = '0; ReqB = '0;
        MulReady = 1'b1; MulProduct = '0;
        @(negedge Clk); @(negedge Clk);
        chk("reset_pulses_prod", {ReqAck, RespValid, Err, Product, Grant, Busy, MulStart},
            64'(0));
        chk("reset_operands", 64'({MulA, MulB}), 64'(0));
        #1 Rst_n = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge Clk);

        // Single operation, multiplier slow to drop ready.
        mm_start_delay = 2;
        ack_log = {}; prod_log = {};
        run_single(0, 16'd4, 16'd5, p, r);
        chk("s1_product", 64'(p), 64'd20);
        chk("s1_resp", 64'(r), 64'b0001);
        chk("s1_ack_count", 64'(ack_log.size()), 64'd1);
        if (ack_log.size() > 0) chk("s1_ack_idx", 64'(ack_log[0]), 64'd0);
        mm_start_delay = 0;

        // Four requesters at once, round robin from a fresh reset.
        do_reset();
        ack_log = {}; prod_log = {};
        @(negedge Clk);
        ReqA = {16'd5, 16'd4, 16'd3, 16'd2}; ReqB = {4{16'd3}}; ReqValid = 4'b1111;
        n_resp = 0; n_ack = 0; low_run = 0; max_low = 0;
        for (int c = 0; c < 400 && n_resp < 4; c++) begin
            @(negedge Clk);
            if (ReqAck != 0) begin ReqValid = ReqValid & ~ReqAck; n_ack++; end
            if (RespValid != 0) n_resp++;
            if (n_ack > 0 && n_resp < 4) begin
                if (!Busy) low_run++;
                else begin if (low_run > max_low) max_low = low_run; low_run = 0; end
            end
        end
        chk("s2_resp_count", 64'(n_resp), 64'd4);
        chk("s2_busy_gap_le1", 64'(max_low <= 1), 64'd1);
        chk("s2_ack_count", 64'(ack_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < ack_log.size(); i++) chk("s2_order", 64'(ack_log[i]), 64'(i));
        for (int i = 0; i < 4 && i < prod_log.size(); i++)
            chk("s2_product", 64'(prod_log[i]), 64'((i + 2) * 3));

        // Requesters 0 and 2 held continuously.
        ack_log = {};
        @(negedge Clk);
        ReqA = {16'd0, 16'd2, 16'd0, 16'd1}; ReqB = {16'd0, 16'd2, 16'd0, 16'd1};
        ReqValid = 4'b0101;
        n_ack = 0; done = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge Clk);
            if (ReqAck != 0) begin
                n_ack++;
                if (n_ack == 4) ReqValid = 4'b0000;
            end
            if (n_ack == 4 && RespValid != 0) done = 1;
        end
        chk("s3_done", 64'(done), 64'd1);
        chk("s3_ack_count", 64'(ack_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < ack_log.size(); i++)
            chk("s3_grant_seq", 64'(ack_log[i]), 64'((i % 2) * 2));

        // Full-scale operands.
        run_single(1, 16'hFFFF, 16'hFFFF, p, r);
        chk("s4_product", 64'(p), 64'hFFFE0001);
        chk("s4_resp", 64'(r), 64'b0010);

        // Reset while RUN is waiting on a long multiplication.
        mm_lat = 20;
        @(negedge Clk);
        ReqA[DW-1:0] = 16'd3; ReqB[DW-1:0] = 16'd3; ReqValid[0] = 1'b1;
        done = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge Clk);
            if (ReqAck[0]) ReqValid[0] = 1'b0;
            if (Busy && !MulStart) done = 1;
        end
        chk("s5_reached_run", 64'(done), 64'd1);
        @(posedge Clk); #2 Rst_n = 1'b0;
        @(negedge Clk);
        chk("s5_rst_pulses_prod", {ReqAck, RespValid, Err, Product, Grant, Busy, MulStart},
            64'(0));
        chk("s5_rst_operands", 64'({MulA, MulB}), 64'(0));
        resp_seen = 0;
        @(negedge Clk); if (RespValid != 0 || Err != 0) resp_seen++;
        #1 Rst_n = 1'b1;
        mm_lat = 3;
        for (int c = 0; c < 5; c++) begin
            @(negedge Clk); if (RespValid != 0 || Err != 0) resp_seen++;
        end
        chk("s5_no_resp", 64'(resp_seen), 64'd0);
        run_single(0, 16'd7, 16'd6, p, r);
        chk("s5_product", 64'(p), 64'd42);
        chk("s5_resp", 64'(r), 64'b0001);

        // Multiplier that ignores MulStart: start timeout.
        mm_ignore = 1;
        @(negedge Clk);
        ReqA[3*DW +: DW] = 16'd2; ReqB[3*DW +: DW] = 16'd9; ReqValid[3] = 1'b1;
        c_ack = -1; c_err = -1; err_v = '0; err_prod = '0; err_mstart = 1'b1; err_busy = 1'b1;
        done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge Clk);
            if (ReqAck[3]) begin ReqValid[3] = 1'b0; c_ack = c; end
            if (Err != 0) begin
                c_err = c; err_v = Err; err_prod = Product;
                err_mstart = MulStart; err_busy = Busy; done = 1;
            end
        end
        chk("s6_err_seen", 64'(done), 64'd1);
        chk("s6_err_latency", 64'(c_err - c_ack), 64'd16);
        chk("s6_err_vec", 64'(err_v), 64'b1000);
        chk("s6_product_kept", 64'(err_prod), 64'd42);
        chk("s6_mulstart", 64'(err_mstart), 64'd0);
        chk("s6_busy", 64'(err_busy), 64'd0);
        repeat (3) @(negedge Clk);
        mm_ignore = 0;
        repeat (3) @(negedge Clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multiplier_arbiter.md
MULTIPLIER_ARBITER -- requirements
Module: multiplier_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving the operand width; product width is 2*DATA_WIDTH.
REQ-002 The block SHALL have parameter START_TIMEOUT, default 16, giving the maximum cycles allowed for MulReady to fall after MulStart rises.
REQ-003 The block SHALL serve a fixed 4 requesters; packed buses place requester i at bits [i*W +: W].
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 The ports SHALL be:
- Clk  in  1  clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- ReqValid  in  4  per-requester request.
- ReqA  in  4*DATA_WIDTH  packed operand A.
- ReqB  in  4*DATA_WIDTH  packed operand B.
- ReqAck  out  4  one-cycle pulse: operands captured.
- RespValid  out  4  one-cycle pulse: Product valid for that requester.
- Err  out  4  one-cycle pulse: operation aborted on timeout.
- Product  out  2*DATA_WIDTH  last result, held until the next response.
- Grant  out  2  index of the current or last owner.
- Busy  out  1  high outside IDLE.
- MulA  out  DATA_WIDTH  operand A to the multiplier.
- MulB  out  DATA_WIDTH  operand B to the multiplier.
- MulStart  out  1  multiplier start.
- MulProduct  in  2*DATA_WIDTH  multiplier result.
- MulReady  in  1  multiplier idle / result valid.

Function
REQ-006 All outputs SHALL be registered.
REQ-007 The FSM SHALL have exactly three states: IDLE, START and RUN.
REQ-008 In IDLE, when any ReqValid bit is 1 and MulReady=1 at a clock edge, the block SHALL grant one requester and enter START.
- If MulReady=0, no grant is made and the block stays in IDLE.
REQ-009 Arbitration SHALL be round-robin.
- Search order is Last+1, Last+2, Last+3, Last (mod 4).
- Last updates to the granted index on every grant, including aborted ones.
REQ-010 On the grant edge the block SHALL:
- latch ReqA/ReqB of the winner into MulA/MulB;
- set Grant to the winner index;
- assert ReqAck[g] for exactly one cycle;
- set MulStart=1 and Busy=1.
REQ-011 Requesters SHALL hold ReqValid and operands until ReqAck; ReqValid still high in the cycle after ReqAck counts as a new request.
REQ-012 In START, MulStart SHALL stay 1 until MulReady is sampled 0; then MulStart drops to 0 and the state moves to RUN.
REQ-013 In START, a cycle counter SHALL count sampled MulReady=1 cycles; when it reaches START_TIMEOUT, the block SHALL:
- drop MulStart;
- pulse Err[g] for one cycle;
- return to IDLE, leaving Product unchanged.
REQ-014 In RUN, when MulReady is sampled 1, the block SHALL:
- register MulProduct into Product;
- pulse RespValid[g] for one cycle;
- return to IDLE with Busy=0.
REQ-015 At most one of ReqAck, RespValid and Err SHALL be non-zero in any cycle, each one-hot or zero.
REQ-016 A new grant MAY occur on the edge after RespValid or Err, since IDLE re-arbitrates immediately.
REQ-017 MulA/MulB SHALL remain stable from the grant through RespValid or Err.
REQ-018 Requests arriving while Busy=1 SHALL wait; none SHALL be lost while ReqValid stays high.
REQ-019 Product SHALL be MulProduct unmodified, 2*DATA_WIDTH bits, with no truncation.
REQ-020 Latency SHALL be:
- grant to ReqAck: 1 cycle;
- MulReady rise in RUN to RespValid: 1 cycle.

Reset
REQ-021 While Rst_n=0, the block SHALL immediately force:
- state IDLE and Last=3;
- ReqAck, RespValid, Err, Product, Grant, Busy, MulA, MulB and MulStart all to 0;
- the timeout counter to 0.
REQ-022 Reset mid-operation SHALL discard the in-flight operation with no RespValid or Err pulse; after release, the first grant SHALL wait for MulReady=1.

Verification
REQ-023 A bench SHALL cover: ReqValid=0001, A0=4, B0=5 -> ReqAck=0001 pulse, MulStart high until MulReady falls, RespValid=0001, Product=20.
REQ-024 A bench SHALL cover: ReqValid=1111 with Ai=i+2, Bi=3, each request dropped after its ack -> serviced in order 0,1,2,3 with Products 6, 9, 12, 15; Busy never low between back-to-back operations for more than 1 cycle.
REQ-025 A bench SHALL cover: requesters 0 and 2 held asserted continuously -> Grant sequence 0,2,0,2; requesters 1 and 3 never acked.
REQ-026 A bench SHALL cover: A=B=16'hFFFF -> Product=32'hFFFE0001.
REQ-027 A bench SHALL cover: Rst_n pulsed low during RUN -> all outputs 0 within the reset cycle and no RespValid; a following request A=7, B=6 -> Product=42 from requester 0.
REQ-028 A bench SHALL cover: a multiplier model holding MulReady=1 and ignoring MulStart -> Err[g] pulse after 16 cycles in START, MulStart=0, state IDLE, Product unchanged.
